cdb_result_arbiter: RTL and testbench

Parametrised Common Data Bus stage for the Tomasulo core. It sits between the N functional units and the CDB consumers (register bank, reservation stations). Each FU result (tag, data) goes into a per-FU FIFO. One result per cycle is broadcast under round-robin arbitration, so it replaces the fixed two-input CDB arbiter. It adds back-pressure, a consumer stall input and illegal-tag detection.

---
 rtl/cdb_result_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_result_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_result_arbiter.sv
// Common Data Bus result stage: per-FU result FIFOs feeding one registered
// broadcast per cycle under round-robin arbitration, with stall and tag-0 detection.
module cdb_result_arbiter #(
    parameter int unsigned N_FU   = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_FU-1:0]          fu_valid,
    output logic [N_FU-1:0]          fu_ready,
    input  logic [N_FU*TAG_W-1:0]    fu_tag,
    input  logic [N_FU*DATA_W-1:0]   fu_data,
    input  logic                     cdb_stall,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [N_FU-1:0]          cdb_grant,
    output logic                     tag_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(N_FU);

    logic [N_FU-1:0]        nonempty;
    logic [N_FU-1:0]        push;
    logic [N_FU-1:0]        pop;
    logic [N_FU-1:0]        bad_push;
    logic [N_FU*TAG_W-1:0]  head_tag;
    logic [N_FU*DATA_W-1:0] head_data;

    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       arb_cand;
    logic                   win_found;
    logic [TAG_W-1:0]       sel_tag;
    logic [DATA_W-1:0]      sel_data;

    // Per-FU result FIFO; fu_ready looks only at the registered count, so a
    // full FIFO refuses a push even on the edge it is popped.
    for (genvar g = 0; g < N_FU; g++) begin : g_fifo
        logic [TAG_W-1:0]  tag_mem  [DEPTH];
        logic [DATA_W-1:0] data_mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic              tag_zero;

        assign tag_zero     = (fu_tag[g*TAG_W +: TAG_W] == '0);
        assign fu_ready[g]  = (count != CNT_W'(DEPTH));
        assign nonempty[g]  = (count != '0);
        assign push[g]      = fu_valid[g] & fu_ready[g] & ~tag_zero;
        assign bad_push[g]  = fu_valid[g] & fu_ready[g] & tag_zero;
        assign head_tag[g*TAG_W +: TAG_W]    = tag_mem[rd_ptr];
        assign head_data[g*DATA_W +: DATA_W] = data_mem[rd_ptr];

        always_ff @(posedge clock) begin
            if (push[g]) begin
                tag_mem[wr_ptr]  <= fu_tag[g*TAG_W +: TAG_W];
                data_mem[wr_ptr] <= fu_data[g*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Round-robin search starting just after the last granted FU.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_cand  = '0;
        for (int unsigned k = 1; k <= N_FU; k++) begin
            arb_cand = IDX_W'((32'(last) + k) % N_FU);
            if (!win_found && nonempty[arb_cand]) begin
                win_found = 1'b1;
                win_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        pop      = '0;
        sel_tag  = head_tag[32'(win_idx)*TAG_W +: TAG_W];
        sel_data = head_data[32'(win_idx)*DATA_W +: DATA_W];
        if (!cdb_stall && win_found) begin
            pop[win_idx] = 1'b1;
        end
    end

    // Broadcast registers; tag/data hold while idle or stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_grant <= '0;
            tag_err   <= 1'b0;
            last      <= IDX_W'(N_FU - 1);
        end else begin
            cdb_valid <= |pop;
            cdb_grant <= pop;
            if (|pop) begin
                cdb_tag  <= sel_tag;
                cdb_data <= sel_data;
                last     <= win_idx;
            end
            if (|bad_push) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Scoreboard bench for cdb_result_arbiter: directed pushes queue expected
// broadcasts; a negedge monitor pops and compares every cdb_valid cycle.
module tb_cdb_result_arbiter;

    localparam int N_FU   = 2;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;
    localparam int DEPTH  = 2;

    logic                   clock;
    logic                   reset;
    logic [N_FU-1:0]        fu_valid;
    logic [N_FU-1:0]        fu_ready;
    logic [N_FU*TAG_W-1:0]  fu_tag;
    logic [N_FU*DATA_W-1:0] fu_data;
    logic                   cdb_stall;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [N_FU-1:0]        cdb_grant;
    logic                   tag_err;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [N_FU-1:0]   grant;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cdb_result_arbiter #(
        .N_FU(N_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_data(fu_data),
        .cdb_stall(cdb_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_grant(cdb_grant), .tag_err(tag_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic add_exp(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data, input int fu);
        exp_t e;
        e.tag   = tag;
        e.data  = data;
        e.grant = N_FU'(1 << fu);
        exp_q.push_back(e);
    endtask

    // Present one result on FU fu and hold it until the handshake completes.
    task automatic push_one(input int fu, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        fu_valid = '0;
        fu_valid[fu] = 1'b1;
        fu_tag[fu*TAG_W +: TAG_W]    = tag;
        fu_data[fu*DATA_W +: DATA_W] = data;
        while (!acc && guard < 50) begin
            acc = fu_ready[fu];
            step(1);
            guard++;
        end
        fu_valid = '0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: fu %0d tag %0d never accepted, required acceptance", fu, tag);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            step(1);
            g++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        step(3);
    endtask

    // Monitor: every broadcast must match the head of the expected queue.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            if (cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_broadcast: got tag %0h data %0h grant %b, expected none",
                             cdb_tag, cdb_data, cdb_grant);
                end else begin
                    e = exp_q.pop_front();
                    check("cdb_result", 32'({cdb_tag, cdb_data, cdb_grant}), 32'({e.tag, e.data, e.grant}));
                end
            end else begin
                check("grant_idle", 32'(cdb_grant), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int   i0;
        int   i1;
        int   e;
        logic [N_FU-1:0] acc;

        // Reset with pushes presented: they must be discarded.
        reset     = 1'b1;
        cdb_stall = 1'b0;
        fu_valid  = 2'b11;
        fu_tag    = {3'd2, 3'd1};
        fu_data   = {16'hbeef, 16'hcafe};
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        fu_valid = '0;
        check("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        check("reset_fu_ready", 32'(fu_ready), 32'h3);
        check("reset_tag_err", 32'(tag_err), 32'd0);
        check("reset_cdb_tag", 32'(cdb_tag), 32'd0);
        check("reset_cdb_data", 32'(cdb_data), 32'd0);
        step(4);
        check("idle_fu_ready", 32'(fu_ready), 32'h3);

        // Single FU latency: accepted at edge t, visible after edge t+1.
        add_exp(3'd3, 16'h0042, 1);
        push_one(1, 3'd3, 16'h0042);
        check("lat_after_t", 32'(cdb_valid), 32'd0);
        step(1);
        check("lat_after_t1_valid", 32'(cdb_valid), 32'd1);
        check("lat_after_t1_grant", 32'(cdb_grant), 32'h2);
        check("lat_after_t1_data", 32'(cdb_data), 32'h0042);
        step(1);
        check("lat_after_t2", 32'(cdb_valid), 32'd0);
        drain();

        // Round-robin: both FUs push every cycle, grants alternate from FU0.
        for (int j = 0; j < 4; j++) begin
            add_exp(3'd1, 16'h0100 + 16'(j), 0);
            add_exp(3'd4, 16'h0200 + 16'(j), 1);
        end
        i0 = 0;
        i1 = 0;
        e  = 0;
        while ((i0 < 4 || i1 < 4) && e < 40) begin
            fu_valid[0] = (i0 < 4);
            fu_valid[1] = (i1 < 4);
            fu_tag      = {3'd4, 3'd1};
            fu_data[15:0]  = 16'h0100 + 16'(i0);
            fu_data[31:16] = 16'h0200 + 16'(i1);
            acc = fu_valid & fu_ready;
            step(1);
            e++;
            if (acc[0]) i0++;
            if (acc[1]) i1++;
            if (e == 2) check("rr_ready_edge2", 32'(fu_ready), 32'h1);
            if (e == 3) check("rr_ready_edge3", 32'(fu_ready), 32'h2);
        end
        fu_valid = '0;
        check("rr_all_accepted", 32'(i0 + i1), 32'd8);
        drain();

        // Stall and back-pressure on FU0.
        cdb_stall = 1'b1;
        add_exp(3'd2, 16'h0001, 0);
        add_exp(3'd2, 16'h0002, 0);
        add_exp(3'd2, 16'h0003, 0);
        push_one(0, 3'd2, 16'h0001);
        push_one(0, 3'd2, 16'h0002);
        check("stall_ready0_full", 32'(fu_ready[0]), 32'd0);
        fu_valid[0] = 1'b1;
        fu_tag[2:0]   = 3'd2;
        fu_data[15:0] = 16'h0003;
        step(3);
        check("stall_third_held", 32'(fu_ready[0]), 32'd0);
        check("stall_no_broadcast", 32'(cdb_valid), 32'd0);
        cdb_stall = 1'b0;
        push_one(0, 3'd2, 16'h0003);
        drain();

        // Illegal tag is dropped and flags a sticky error.
        push_one(0, 3'd0, 16'hdead);
        check("tag_err_set", 32'(tag_err), 32'd1);
        step(3);
        check("tag_err_sticky", 32'(tag_err), 32'd1);

        // Five sequential results through a depth-2 FIFO across pointer wrap.
        for (int k = 1; k <= 5; k++) begin
            add_exp(3'(k), 16'h0050 + 16'(k), 0);
            push_one(0, 3'(k), 16'h0050 + 16'(k));
        end
        drain();
        check("tag_err_still_set", 32'(tag_err), 32'd1);

        // Reset mid-flight: buffered results are lost, never broadcast.
        cdb_stall = 1'b1;
        fu_valid  = 2'b11;
        fu_tag    = {3'd7, 3'd6};
        fu_data   = {16'h0777, 16'h0666};
        step(2);
        fu_valid = '0;
        check("midflight_full", 32'(fu_ready), 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("midrst_fu_ready", 32'(fu_ready), 32'h3);
        check("midrst_tag_err", 32'(tag_err), 32'd0);
        cdb_stall = 1'b0;
        step(10);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
